// File: rtl/ahb_arbiter_if.sv
// Arbiter request/grant bundle shared by the masters and the burst-aware arbiter.
// Lock signals exist only when AHB_ARB_LOCK_EN is defined.
interface ahb_arbiter_if #(
    parameter int AHB_MASTER_NUM = 4,
    parameter int AHB_MID_WIDTH  = $clog2(AHB_MASTER_NUM)
);
    logic [AHB_MASTER_NUM-1:0] ahb_req_in;
    logic [1:0]                ahb_trans_in;
    logic [2:0]                ahb_burst_in;
    logic                      ahb_ready_in;
    logic [AHB_MASTER_NUM-1:0] ahb_grant_out;
    logic [AHB_MID_WIDTH-1:0]  ahb_master_out;
    logic [AHB_MID_WIDTH-1:0]  ahb_master_data_out;
`ifdef AHB_ARB_LOCK_EN
    logic [AHB_MASTER_NUM-1:0] ahb_lock_in;
    logic                      ahb_mastlock_out;

    modport slave (
        input  ahb_req_in, ahb_trans_in, ahb_burst_in, ahb_ready_in, ahb_lock_in,
        output ahb_grant_out, ahb_master_out, ahb_master_data_out, ahb_mastlock_out
    );
    modport master (
        output ahb_req_in, ahb_trans_in, ahb_burst_in, ahb_ready_in, ahb_lock_in,
        input  ahb_grant_out, ahb_master_out, ahb_master_data_out, ahb_mastlock_out
    );
`else
    modport slave (
        input  ahb_req_in, ahb_trans_in, ahb_burst_in, ahb_ready_in,
        output ahb_grant_out, ahb_master_out, ahb_master_data_out
    );
    modport master (
        output ahb_req_in, ahb_trans_in, ahb_burst_in, ahb_ready_in,
        input  ahb_grant_out, ahb_master_out, ahb_master_data_out
    );
`endif
endinterface

// File: rtl/ahb_arbiter.sv
// Burst-aware round-robin AHB arbiter; optional HMASTLOCK support under AHB_ARB_LOCK_EN.
// Latency: grant/owner registered, one cycle from a re-arbitration point.
// Backpressure: ahb_ready_in low freezes grant, owner indices, beat counter and state.
module ahb_arbiter #(
    parameter int AHB_MASTER_NUM = 4,
    parameter int AHB_MID_WIDTH  = $clog2(AHB_MASTER_NUM)
) (
    input logic          ahb_clk_in,
    input logic          ahb_rst_in,
    ahb_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_XFER  = 2'd1,
        ST_BURST = 2'd2
    } state_e;

    localparam logic [1:0] TR_IDLE   = 2'b00;
    localparam logic [1:0] TR_BUSY   = 2'b01;
    localparam logic [1:0] TR_NONSEQ = 2'b10;
    localparam logic [1:0] TR_SEQ    = 2'b11;
    localparam logic [2:0] BU_SINGLE = 3'd0;
    localparam logic [2:0] BU_INCR   = 3'd1;

    state_e                    state_q;
    logic [3:0]                cnt_q, cnt_d;
    logic [AHB_MID_WIDTH-1:0]  owner_q, owner_d;
    logic [AHB_MID_WIDTH-1:0]  data_owner_q;
    logic [AHB_MASTER_NUM-1:0] grant_q, grant_d;
    logic [3:0]                len_m1;
    logic                      fixed_burst;
    logic                      rearb;

    // First requester after the current owner, wrapping back to the owner itself.
    function automatic logic [AHB_MID_WIDTH-1:0] rr_pick(
        input logic [AHB_MASTER_NUM-1:0] req,
        input logic [AHB_MID_WIDTH-1:0]  cur
    );
        logic [AHB_MID_WIDTH-1:0] pick;
        logic                     found;
        int                       idx;
        pick  = cur;
        found = 1'b0;
        for (int i = 1; i <= AHB_MASTER_NUM; i++) begin
            idx = int'(cur) + i;
            if (idx >= AHB_MASTER_NUM) begin
                idx = idx - AHB_MASTER_NUM;
            end
            if (!found && req[idx[AHB_MID_WIDTH-1:0]]) begin
                pick  = idx[AHB_MID_WIDTH-1:0];
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    always_comb begin
        len_m1 = 4'd0;
        unique case (bus.ahb_burst_in)
            3'd2, 3'd3: len_m1 = 4'd3;
            3'd4, 3'd5: len_m1 = 4'd7;
            3'd6, 3'd7: len_m1 = 4'd15;
            default:    len_m1 = 4'd0;
        endcase
        fixed_burst = (bus.ahb_burst_in != BU_SINGLE) && (bus.ahb_burst_in != BU_INCR);
    end

    always_comb begin
        rearb = 1'b0;
        if (bus.ahb_ready_in) begin
            unique case (bus.ahb_trans_in)
                TR_IDLE:   rearb = 1'b1;
                TR_NONSEQ: rearb = (bus.ahb_burst_in == BU_SINGLE);
                TR_SEQ:    rearb = (cnt_q == 4'd1);
                default:   rearb = 1'b0;
            endcase
            // An undefined-length burst ends when its owner stops requesting.
            if (state_q == ST_XFER && bus.ahb_burst_in == BU_INCR &&
                bus.ahb_trans_in[1] && !bus.ahb_req_in[owner_q]) begin
                rearb = 1'b1;
            end
        end
`ifdef AHB_ARB_LOCK_EN
        if (bus.ahb_lock_in[owner_q]) begin
            rearb = 1'b0;
        end
`endif
    end

    always_comb begin
        owner_d = rearb ? rr_pick(bus.ahb_req_in, owner_q) : owner_q;
        grant_d = '0;
        grant_d[owner_d] = 1'b1;

        cnt_d = cnt_q;
        unique case (bus.ahb_trans_in)
            TR_IDLE:   cnt_d = 4'd0;
            TR_NONSEQ: cnt_d = len_m1;
            TR_SEQ:    cnt_d = (cnt_q != 4'd0) ? cnt_q - 4'd1 : 4'd0;
            default:   cnt_d = cnt_q;
        endcase
    end

`ifdef AHB_ARB_LOCK_EN
    logic mastlock_q;

    always_ff @(posedge ahb_clk_in) begin
        if (ahb_rst_in) begin
            mastlock_q <= 1'b0;
        end else if (bus.ahb_ready_in) begin
            mastlock_q <= bus.ahb_lock_in[owner_q];
        end
    end

    assign bus.ahb_mastlock_out = mastlock_q;
`endif

    always_ff @(posedge ahb_clk_in) begin
        if (ahb_rst_in) begin
            state_q      <= ST_IDLE;
            cnt_q        <= 4'd0;
            owner_q      <= '0;
            data_owner_q <= '0;
            grant_q      <= {{(AHB_MASTER_NUM-1){1'b0}}, 1'b1};
        end else if (bus.ahb_ready_in) begin
            cnt_q        <= cnt_d;
            owner_q      <= owner_d;
            grant_q      <= grant_d;
            data_owner_q <= owner_q;
            unique case (state_q)
                ST_IDLE: begin
                    if (bus.ahb_trans_in == TR_NONSEQ) begin
                        state_q <= fixed_burst ? ST_BURST : ST_XFER;
                    end
                end
                ST_XFER, ST_BURST: begin
                    if (bus.ahb_trans_in == TR_IDLE) begin
                        state_q <= ST_IDLE;
                    end else if (bus.ahb_trans_in == TR_NONSEQ) begin
                        state_q <= fixed_burst ? ST_BURST : ST_XFER;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.ahb_grant_out       = grant_q;
    assign bus.ahb_master_out      = owner_q;
    assign bus.ahb_master_data_out = data_owner_q;
endmodule
